ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the EX stage. It accepts one operation from ID/EX, holds the pipeline through a stall request while it iterates, then returns the result and destination info for the EX/MEM mux.
- Multiplier retires MUL_STEP partial-product bits per cycle (radix-2^MUL_STEP shift-add). Divider is restoring, 1 quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must be one of 1, 2 or 4, and must divide XLEN.
- REG_ADDR_W, 5, destination register address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset asserted at the clock edge).
- start_i  in  1  operation request from ID/EX.
- op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- reg1_i  in  XLEN  rs1 value (multiplicand / dividend).
- reg2_i  in  XLEN  rs2 value (multiplier / divisor).
- wd_i  in  REG_ADDR_W  destination register address.
- wreg_i  in  1  write-enable for the destination register.
- flush_i  in  1  pipeline clean (branch taken); aborts the operation.
- busy_o  out  1  state != IDLE.
- stallreq_o  out  1  stall request to pipeline control.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result; meaningful only while valid_o=1, else 0.
- wd_o  out  REG_ADDR_W  latched wd_i.
- wreg_o  out  1  latched wreg_i, gated by valid_o.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=0 at edge): state IDLE, counter 0, all internal registers 0. All outputs 0: busy_o, stallreq_o, valid_o, result_o, wd_o, wreg_o. Reset mid-operation aborts with no valid_o.
- Accept: IDLE && start_i && !flush_i at an edge (cycle 0).
  - Latch op, wd_i and wreg_i.
  - Latch absolute values of the operands and the result-sign flags:
    - signed: MULH, DIV, REM use both operands signed.
    - mixed: MULHSU has rs1 signed, rs2 unsigned.
    - unsigned: MUL, MULHU, DIVU, REMU.
    - MUL's low word is sign-independent.
  - Clear the 2*XLEN accumulator / remainder and the counter; go to CALC.
- start_i outside IDLE is ignored. No queuing.
- CALC iteration count N:
  - Multiply ops: N = XLEN/MUL_STEP cycles.
  - Divide ops: N = XLEN cycles.
  - Counter increments each cycle. On the edge ending the Nth CALC cycle, apply sign correction (two's-complement negate if needed), register result_o, and go to DONE.
- Arithmetic:
  - Product is 2*XLEN wide.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases, always produced regardless of path:
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1, remainder 0.
- DONE lasts exactly 1 cycle: valid_o=1, result_o valid, wreg_o=latched wreg. Next edge returns to IDLE.
- Latency (no fast path): valid_o in cycle N+1 after the accept cycle.
  - XLEN=32, MUL_STEP=1: mul and div both in cycle 33.
  - XLEN=32, MUL_STEP=4: mul in cycle 9.
- stallreq_o = (IDLE && start_i && !flush_i) || CALC. It is low in DONE, so the pipeline advances and captures the result that cycle.
- flush_i: in any state, next state is IDLE with no valid_o; outputs clear next cycle. Flush has priority over start and over the CALC->DONE transition. If flush_i coincides with DONE, the current-cycle valid_o stands; the pipeline discards it via its own clean.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined: at accept, the following skip CALC and go IDLE->DONE directly, with valid_o in cycle 1 and stallreq_o high only in the accept cycle:
  - divide by zero;
  - signed overflow;
  - a multiply with either operand 0.
- Undefined: these cases take the full N-cycle latency. Results are identical in both builds.

Test Plan:
- MUL 7 x 0xFFFFFFFD (XLEN=32, MUL_STEP=1) -> valid_o in cycle 33, result 0xFFFFFFEB, stallreq_o high cycles 0..32, low at 33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. With MUL_STEP=4, valid_o in cycle 9.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF. REMU 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
  - Macro defined: valid_o in cycle 1.
  - Macro undefined: valid_o in cycle 33.
- flush_i at cycle 10 of a DIV -> no valid_o ever, busy_o=0 from cycle 11. A start at cycle 11 is accepted; start asserted during CALC is ignored.
- rst=0 at cycle 5 of a MUL -> all outputs 0 next cycle, IDLE. A fresh MUL 3 x 4 then yields 12 with wd_o = the new wd_i.

Source files
------------

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiplier (MUL_STEP bits/cycle) and restoring divider.
// Optional build macro MULDIV_FASTPATH_EN: trivial operations skip the iteration phase.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STEP   = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       reg1_i,
    input  logic [XLEN-1:0]       reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    // Handshake: an operation is taken on any edge where the unit is IDLE, start_i=1
    // and flush_i=0; its result is presented for exactly one cycle with valid_o=1 and
    // there is no backpressure on the result side.
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q;
    logic [REG_ADDR_W-1:0]   wd_q;
    logic                    wreg_q;
    logic [XLEN-1:0]         a_q, b_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    neg_q;
    logic                    spec_q;
    logic [XLEN-1:0]         spec_res_q;
    logic [XLEN-1:0]         result_q;

    // Operand preparation at accept time
    logic            is_div_in, s1_sig, s2_sig, neg1, neg2, neg_in;
    logic            div0, ovf, spec_in, fast_in, accept;
    logic [XLEN-1:0] abs1, abs2, spec_res_in;

    always_comb begin
        is_div_in = op_i[2];
        s1_sig    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        s2_sig    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        neg1      = s1_sig && reg1_i[XLEN-1];
        neg2      = s2_sig && reg2_i[XLEN-1];
        abs1      = neg1 ? -reg1_i : reg1_i;
        abs2      = neg2 ? -reg2_i : reg2_i;
        // Remainder follows the dividend; quotient and products follow the sign product.
        neg_in    = (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
        div0      = is_div_in && (reg2_i == '0);
        ovf       = is_div_in && !op_i[0] && (reg1_i == INT_MIN) && (reg2_i == '1);
        spec_in   = div0 || ovf;
        spec_res_in = '0;
        if (div0)
            spec_res_in = op_i[1] ? reg1_i : '1;
        else if (ovf)
            spec_res_in = op_i[1] ? '0 : reg1_i;
`ifdef MULDIV_FASTPATH_EN
        fast_in = spec_in || (!is_div_in && ((reg1_i == '0) || (reg2_i == '0)));
`else
        fast_in = 1'b0;
`endif
        accept = (state_q == IDLE) && start_i && !flush_i;
    end

    // Iteration datapath
    logic              is_div_q, last;
    logic [XLEN+MUL_STEP-1:0] pp, msum;
    logic [XLEN:0]     trial, diff;
    logic [2*XLEN-1:0] mul_acc, div_acc, acc_d, prod_n;
    logic [XLEN-1:0]   mul_res, div_raw, div_res, final_res;

    always_comb begin
        is_div_q = op_q[2];
        pp       = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[MUL_STEP-1:0]};
        msum     = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
        mul_acc  = {msum, acc_q[XLEN-1:MUL_STEP]};
        // Remainder lives in the upper half, quotient bits shift into the lower half.
        trial    = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        diff     = trial - {1'b0, b_q};
        div_acc  = diff[XLEN] ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_d    = is_div_q ? div_acc : mul_acc;
        last     = (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST));
        prod_n   = neg_q ? -acc_d : acc_d;
        mul_res  = (op_q[1:0] == 2'd0) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN];
        div_raw  = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
        div_res  = neg_q ? -div_raw : div_raw;
        final_res = spec_q ? spec_res_q : (is_div_q ? div_res : mul_res);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast_in ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q       <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else if (flush_i) begin
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_i;
                        wd_q       <= wd_i;
                        wreg_q     <= wreg_i;
                        a_q        <= abs1;
                        b_q        <= abs2;
                        neg_q      <= neg_in;
                        spec_q     <= spec_in;
                        spec_res_q <= spec_res_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        if (fast_in)
                            result_q <= spec_res_in;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div_q)
                        a_q <= {a_q[XLEN-2:0], 1'b0};
                    else
                        b_q <= b_q >> MUL_STEP;
                    if (last)
                        result_q <= final_res;
                end
                DONE:    result_q <= '0;
                default: result_q <= '0;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign stallreq_o = accept || (state_q == CALC);
    assign valid_o    = (state_q == DONE);
    assign result_o   = result_q;
    assign wd_o       = wd_q;
    assign wreg_o     = valid_o && wreg_q;

endmodule
